// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings and burst-length decode for the round-robin arbiter.
package ahb_arb_pkg;

  localparam int unsigned RemW = 5;

  typedef enum logic [1:0] {
    TransIdle   = 2'd0,
    TransBusy   = 2'd1,
    TransNonseq = 2'd2,
    TransSeq    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BurstSingle = 3'd0,
    BurstIncr   = 3'd1,
    BurstWrap4  = 3'd2,
    BurstIncr4  = 3'd3,
    BurstWrap8  = 3'd4,
    BurstIncr8  = 3'd5,
    BurstWrap16 = 3'd6,
    BurstIncr16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    RespOkay  = 2'd0,
    RespError = 2'd1,
    RespRetry = 2'd2,
    RespSplit = 2'd3
  } hresp_e;

  // Beats in a burst; 0 marks an undefined-length INCR.
  function automatic logic [RemW-1:0] burst_len(input logic [2:0] burst);
    logic [RemW-1:0] len;
    case (burst)
      BurstSingle:            len = 5'd1;
      BurstIncr:              len = 5'd0;
      BurstWrap4, BurstIncr4: len = 5'd4;
      BurstWrap8, BurstIncr8: len = 5'd8;
      default:                len = 5'd16;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_arbiter_rr_if.sv
// Bus-side signal bundle for the AHB round-robin arbiter.
interface ahb_arbiter_rr_if #(
  parameter int unsigned N_MASTER = 3,
  parameter int unsigned W_MASTER = 2
);

  logic [N_MASTER-1:0] HBUSREQ;
  logic [N_MASTER-1:0] HLOCK;
  logic [1:0]          HTRANS;
  logic [2:0]          HBURST;
  logic                HREADY;
  logic [1:0]          HRESP;
  logic [N_MASTER-1:0] HSPLIT;
  logic [N_MASTER-1:0] HGRANT;
  logic [W_MASTER-1:0] HMASTER;
  logic [W_MASTER-1:0] HMASTER_del;
  logic                HMASTLOCK;

  // Arbiter side.
  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
    output HGRANT, HMASTER, HMASTER_del, HMASTLOCK
  );

  // Masters / shared bus side.
  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
    input  HGRANT, HMASTER, HMASTER_del, HMASTLOCK
  );

endinterface

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first request after 'last', wrapping at N_MASTER-1.
module ahb_rr_pick #(
  parameter int unsigned N_MASTER = 3,
  parameter int unsigned W_MASTER = 2
) (
  input  logic [N_MASTER-1:0] req,
  input  logic [W_MASTER-1:0] last,
  output logic [N_MASTER-1:0] gnt,
  output logic                valid
);

  logic [W_MASTER-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    // Offset N_MASTER revisits 'last' itself, so it is the lowest priority.
    for (int unsigned i = 1; i <= N_MASTER; i++) begin
      idx = W_MASTER'((32'(last) + i) % N_MASTER);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter with round-robin priority, burst/lock hold and optional SPLIT masking
// (SPLIT masking compiled in with AHB_ARB_SPLIT_EN).
module ahb_arbiter_rr
  import ahb_arb_pkg::*;
#(
  parameter int unsigned N_MASTER       = 3,
  parameter int unsigned W_MASTER       = 2,
  parameter int unsigned NUM_DEF_MASTER = 0
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_arbiter_rr_if.slave bus
);

  localparam logic [N_MASTER-1:0] DefGrant = {{(N_MASTER-1){1'b0}}, 1'b1} << NUM_DEF_MASTER;
  localparam logic [W_MASTER-1:0] DefIdx   = W_MASTER'(NUM_DEF_MASTER);

  logic [N_MASTER-1:0] grant_q, grant_d;
  logic [N_MASTER-1:0] mask_q;
  logic [N_MASTER-1:0] req_eff, pick_gnt;
  logic [W_MASTER-1:0] hmaster_q, hmaster_d;
  logic [W_MASTER-1:0] hmaster_del_q, hmaster_del_d;
  logic [W_MASTER-1:0] grant_idx;
  logic [RemW-1:0]     rem_q, rem_d, len;
  logic                hmastlock_q, hmastlock_d;
  logic                first_q;
  logic                split_force_q;
  logic                pick_valid, arb_point, xfer_idle, burst_free;

  function automatic logic [W_MASTER-1:0] onehot_idx(input logic [N_MASTER-1:0] oh);
    logic [W_MASTER-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      if (oh[i]) idx |= W_MASTER'(i);
    end
    return idx;
  endfunction

  assign grant_idx = onehot_idx(grant_q);
  assign req_eff   = bus.HBUSREQ & ~mask_q;

  // The granted master becomes HMASTER on an arbitration edge, so it anchors the rotation.
  ahb_rr_pick #(
    .N_MASTER (N_MASTER),
    .W_MASTER (W_MASTER)
  ) u_pick (
    .req   (req_eff),
    .last  (grant_idx),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    len   = burst_len(bus.HBURST);
    rem_d = rem_q;
    if (bus.HREADY) begin
      if (bus.HTRANS == TransNonseq) begin
        rem_d = (len == '0) ? '0 : len - 5'd1;
      end else if (bus.HTRANS == TransSeq && rem_q != '0) begin
        rem_d = rem_q - 5'd1;
      end
    end
  end

  always_comb begin
    xfer_idle  = (bus.HTRANS == TransIdle) || (bus.HTRANS == TransBusy);
    burst_free = (bus.HBURST == BurstSingle) || (bus.HBURST == BurstIncr);
    arb_point  = first_q ||
                 (bus.HREADY && (split_force_q ||
                  (!bus.HLOCK[hmaster_q] && (xfer_idle || burst_free || rem_d <= 5'd1))));

    grant_d = grant_q;
    if (arb_point) grant_d = pick_valid ? pick_gnt : DefGrant;

    hmaster_d     = hmaster_q;
    hmaster_del_d = hmaster_del_q;
    hmastlock_d   = hmastlock_q;
    if (bus.HREADY) begin
      hmaster_d     = grant_idx;
      hmaster_del_d = hmaster_q;
      hmastlock_d   = bus.HLOCK[grant_idx];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q       <= DefGrant;
      hmaster_q     <= DefIdx;
      hmaster_del_q <= DefIdx;
      hmastlock_q   <= 1'b0;
      rem_q         <= '0;
      first_q       <= 1'b1;
    end else begin
      grant_q       <= grant_d;
      hmaster_q     <= hmaster_d;
      hmaster_del_q <= hmaster_del_d;
      hmastlock_q   <= hmastlock_d;
      rem_q         <= rem_d;
      first_q       <= 1'b0;
    end
  end

`ifdef AHB_ARB_SPLIT_EN
  logic [N_MASTER-1:0] mask_d;
  logic                split_first, split_force_d;

  always_comb begin
    split_first = (bus.HRESP == RespSplit) && !bus.HREADY && !split_force_q;
    // Clear first so a same-edge set on the same bit wins.
    mask_d = mask_q & ~bus.HSPLIT;
    if (split_first) mask_d[hmaster_del_q] = 1'b1;
    split_force_d = split_force_q;
    if (split_first) begin
      split_force_d = 1'b1;
    end else if (bus.HREADY) begin
      split_force_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mask_q        <= '0;
      split_force_q <= 1'b0;
    end else begin
      mask_q        <= mask_d;
      split_force_q <= split_force_d;
    end
  end
`else
  logic unused_split;
  assign mask_q        = '0;
  assign split_force_q = 1'b0;
  assign unused_split  = ^{bus.HSPLIT, bus.HRESP};
`endif

  assign bus.HGRANT      = grant_q;
  assign bus.HMASTER     = hmaster_q;
  assign bus.HMASTER_del = hmaster_del_q;
  assign bus.HMASTLOCK   = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Self-checking bench for ahb_arbiter_rr; split scenarios run when AHB_ARB_SPLIT_EN is defined.
module tb_ahb_arbiter_rr;
  import ahb_arb_pkg::*;

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] hm;
    logic [1:0] del;
    logic       ml;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [2:0] req;
    logic [2:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [1:0] resp;
    logic [2:0] split;
    exp_t       exp;
  } row_t;

  logic HCLK;
  logic HRESETn;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  ahb_arbiter_rr_if #(.N_MASTER(3), .W_MASTER(2)) bus ();

  ahb_arbiter_rr #(
    .N_MASTER       (3),
    .W_MASTER       (2),
    .NUM_DEF_MASTER (0)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic row_t mk(input logic rst, input logic [2:0] req, input logic [2:0] lock,
                              input logic [1:0] trans, input logic [2:0] burst,
                              input logic ready, input logic [1:0] resp,
                              input logic [2:0] split, input logic [2:0] gnt,
                              input logic [1:0] hm, input logic [1:0] del, input logic ml);
    row_t r;
    r.rst = rst;  r.req = req;     r.lock = lock; r.trans = trans; r.burst = burst;
    r.ready = ready; r.resp = resp; r.split = split;
    r.exp = '{gnt: gnt, hm: hm, del: del, ml: ml};
    return r;
  endfunction

  task automatic drive(input row_t r);
    HRESETn     = ~r.rst;
    bus.HBUSREQ = r.req;
    bus.HLOCK   = r.lock;
    bus.HTRANS  = r.trans;
    bus.HBURST  = r.burst;
    bus.HREADY  = r.ready;
    bus.HRESP   = r.resp;
    bus.HSPLIT  = r.split;
  endtask

  // Reset, release with m2 requesting, then a reset in the middle of an INCR16.
  task automatic test_reset();
    row_t rows[$]; exp_t e; logic [7:0] got;
    rows.push_back(mk(1, 3'b000, 0, TransIdle,   BurstSingle, 1, RespOkay, 0, 3'b001, 0, 0, 0));
    rows.push_back(mk(0, 3'b100, 0, TransIdle,   BurstSingle, 1, RespOkay, 0, 3'b100, 0, 0, 0));
    rows.push_back(mk(0, 3'b100, 0, TransIdle,   BurstSingle, 1, RespOkay, 0, 3'b100, 2, 0, 0));
    rows.push_back(mk(0, 3'b100, 0, TransNonseq, BurstIncr16, 1, RespOkay, 0, 3'b100, 2, 2, 0));
    rows.push_back(mk(1, 3'b100, 0, TransSeq,    BurstIncr16, 1, RespOkay, 0, 3'b001, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, TransNonseq, BurstIncr16, 1, RespOkay, 0, 3'b010, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, TransSeq,    BurstIncr16, 1, RespOkay, 0, 3'b010, 1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].exp);
      @(posedge HCLK); #1;
      e = sb.pop_front(); got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_del, bus.HMASTLOCK};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset row %0d: gnt/hm/del/lock got %b want %b", i, got, e);
      end
      @(negedge HCLK);
    end
  endtask

  task automatic test_round_robin();
    row_t rows[$]; exp_t e; logic [7:0] got;
    rows.push_back(mk(1, 3'b000, 0, TransIdle, BurstSingle, 1, RespOkay, 0, 3'b001, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, TransIdle, BurstSingle, 1, RespOkay, 0, 3'b010, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, TransIdle, BurstSingle, 1, RespOkay, 0, 3'b010, 1, 0, 0));
    rows.push_back(mk(0, 3'b111, 0, TransIdle, BurstSingle, 1, RespOkay, 0, 3'b100, 1, 1, 0));
    rows.push_back(mk(0, 3'b111, 0, TransIdle, BurstSingle, 1, RespOkay, 0, 3'b001, 2, 1, 0));
    rows.push_back(mk(0, 3'b111, 0, TransIdle, BurstSingle, 1, RespOkay, 0, 3'b010, 0, 2, 0));
    rows.push_back(mk(0, 3'b000, 0, TransIdle, BurstSingle, 1, RespOkay, 0, 3'b001, 1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].exp);
      @(posedge HCLK); #1;
      e = sb.pop_front(); got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_del, bus.HMASTLOCK};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL round_robin row %0d: gnt/hm/del/lock got %b want %b", i, got, e);
      end
      @(negedge HCLK);
    end
  endtask

  // m1 runs INCR4 while m2 waits; an optional wait state on beat 2 shifts the handover.
  task automatic test_burst_hold(input bit wait_state);
    row_t rows[$]; exp_t e; logic [7:0] got;
    rows.push_back(mk(1, 3'b000, 0, TransIdle,   BurstSingle, 1, RespOkay, 0, 3'b001, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, TransIdle,   BurstSingle, 1, RespOkay, 0, 3'b010, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, TransIdle,   BurstSingle, 1, RespOkay, 0, 3'b010, 1, 0, 0));
    rows.push_back(mk(0, 3'b110, 0, TransNonseq, BurstIncr4,  1, RespOkay, 0, 3'b010, 1, 1, 0));
    if (wait_state)
      rows.push_back(mk(0, 3'b110, 0, TransSeq,  BurstIncr4,  0, RespOkay, 0, 3'b010, 1, 1, 0));
    rows.push_back(mk(0, 3'b110, 0, TransSeq,    BurstIncr4,  1, RespOkay, 0, 3'b010, 1, 1, 0));
    rows.push_back(mk(0, 3'b100, 0, TransSeq,    BurstIncr4,  1, RespOkay, 0, 3'b100, 1, 1, 0));
    rows.push_back(mk(0, 3'b100, 0, TransSeq,    BurstIncr4,  1, RespOkay, 0, 3'b100, 2, 1, 0));
    rows.push_back(mk(0, 3'b100, 0, TransIdle,   BurstSingle, 1, RespOkay, 0, 3'b100, 2, 2, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].exp);
      @(posedge HCLK); #1;
      e = sb.pop_front(); got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_del, bus.HMASTLOCK};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL burst_hold(wait=%0d) row %0d: gnt/hm/del/lock got %b want %b",
                 wait_state, i, got, e);
      end
      @(negedge HCLK);
    end
  endtask

  task automatic test_lock();
    row_t rows[$]; exp_t e; logic [7:0] got;
    rows.push_back(mk(1, 3'b000, 3'b000, TransIdle,   BurstSingle, 1, RespOkay, 0, 3'b001, 0, 0, 0));
    rows.push_back(mk(0, 3'b001, 3'b000, TransIdle,   BurstSingle, 1, RespOkay, 0, 3'b001, 0, 0, 0));
    rows.push_back(mk(0, 3'b011, 3'b001, TransNonseq, BurstSingle, 1, RespOkay, 0, 3'b001, 0, 0, 1));
    rows.push_back(mk(0, 3'b011, 3'b001, TransNonseq, BurstSingle, 1, RespOkay, 0, 3'b001, 0, 0, 1));
    rows.push_back(mk(0, 3'b011, 3'b000, TransIdle,   BurstSingle, 1, RespOkay, 0, 3'b010, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 3'b000, TransIdle,   BurstSingle, 1, RespOkay, 0, 3'b010, 1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].exp);
      @(posedge HCLK); #1;
      e = sb.pop_front(); got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_del, bus.HMASTLOCK};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL lock row %0d: gnt/hm/del/lock got %b want %b", i, got, e);
      end
      @(negedge HCLK);
    end
  endtask

`ifdef AHB_ARB_SPLIT_EN
  // SPLIT to m1 mid-INCR8, m1 held off until HSPLIT[1] releases it.
  task automatic test_split();
    row_t rows[$]; exp_t e; logic [7:0] got;
    rows.push_back(mk(1, 3'b000, 0, TransIdle,   BurstSingle, 1, RespOkay,  0,      3'b001, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, TransIdle,   BurstSingle, 1, RespOkay,  0,      3'b010, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, TransIdle,   BurstSingle, 1, RespOkay,  0,      3'b010, 1, 0, 0));
    rows.push_back(mk(0, 3'b110, 0, TransNonseq, BurstIncr8,  1, RespOkay,  0,      3'b010, 1, 1, 0));
    rows.push_back(mk(0, 3'b110, 0, TransSeq,    BurstIncr8,  1, RespOkay,  0,      3'b010, 1, 1, 0));
    rows.push_back(mk(0, 3'b110, 0, TransSeq,    BurstIncr8,  0, RespSplit, 0,      3'b010, 1, 1, 0));
    rows.push_back(mk(0, 3'b110, 0, TransSeq,    BurstIncr8,  1, RespSplit, 0,      3'b100, 1, 1, 0));
    rows.push_back(mk(0, 3'b110, 0, TransIdle,   BurstSingle, 1, RespOkay,  0,      3'b100, 2, 1, 0));
    rows.push_back(mk(0, 3'b110, 0, TransIdle,   BurstSingle, 1, RespOkay,  0,      3'b100, 2, 2, 0));
    rows.push_back(mk(0, 3'b110, 0, TransIdle,   BurstSingle, 1, RespOkay,  3'b010, 3'b100, 2, 2, 0));
    rows.push_back(mk(0, 3'b110, 0, TransIdle,   BurstSingle, 1, RespOkay,  0,      3'b010, 2, 2, 0));
    rows.push_back(mk(0, 3'b010, 0, TransIdle,   BurstSingle, 1, RespOkay,  0,      3'b010, 1, 2, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].exp);
      @(posedge HCLK); #1;
      e = sb.pop_front(); got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_del, bus.HMASTLOCK};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL split row %0d: gnt/hm/del/lock got %b want %b", i, got, e);
      end
      @(negedge HCLK);
    end
  endtask

  // Split m1 then m2, leaving mask=110; requests from m1/m2 then fall to the default master.
  task automatic test_all_masked();
    row_t rows[$]; exp_t e; logic [7:0] got;
    rows.push_back(mk(1, 3'b000, 0, TransIdle,   BurstSingle, 1, RespOkay,  0, 3'b001, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, TransIdle,   BurstSingle, 1, RespOkay,  0, 3'b010, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, TransIdle,   BurstSingle, 1, RespOkay,  0, 3'b010, 1, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, TransNonseq, BurstSingle, 1, RespOkay,  0, 3'b010, 1, 1, 0));
    rows.push_back(mk(0, 3'b110, 0, TransIdle,   BurstSingle, 0, RespSplit, 0, 3'b010, 1, 1, 0));
    rows.push_back(mk(0, 3'b110, 0, TransIdle,   BurstSingle, 1, RespSplit, 0, 3'b100, 1, 1, 0));
    rows.push_back(mk(0, 3'b100, 0, TransNonseq, BurstSingle, 1, RespOkay,  0, 3'b100, 2, 1, 0));
    rows.push_back(mk(0, 3'b100, 0, TransNonseq, BurstSingle, 1, RespOkay,  0, 3'b100, 2, 2, 0));
    rows.push_back(mk(0, 3'b110, 0, TransIdle,   BurstSingle, 0, RespSplit, 0, 3'b100, 2, 2, 0));
    rows.push_back(mk(0, 3'b110, 0, TransIdle,   BurstSingle, 1, RespSplit, 0, 3'b001, 2, 2, 0));
    rows.push_back(mk(0, 3'b110, 0, TransIdle,   BurstSingle, 1, RespOkay,  0, 3'b001, 0, 2, 0));
    rows.push_back(mk(0, 3'b111, 0, TransIdle,   BurstSingle, 1, RespOkay,  0, 3'b001, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].exp);
      @(posedge HCLK); #1;
      e = sb.pop_front(); got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_del, bus.HMASTLOCK};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL all_masked row %0d: gnt/hm/del/lock got %b want %b", i, got, e);
      end
      @(negedge HCLK);
    end
  endtask
`endif

  initial begin
    drive(mk(1, 3'b000, 0, TransIdle, BurstSingle, 1, RespOkay, 0, 3'b001, 0, 0, 0));
    @(negedge HCLK);
    test_reset();
    test_round_robin();
    test_burst_hold(1'b0);
    test_burst_hold(1'b1);
    test_lock();
`ifdef AHB_ARB_SPLIT_EN
    test_split();
    test_all_masked();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter_rr.md
AHB_ARBITER_RR -- requirements
Module: ahb_arbiter_rr

Interface
REQ-001 SHALL have parameter N_MASTER, default 3: number of bus masters (2..16).
REQ-002 SHALL have parameter W_MASTER, default 2: ceil(log2(N_MASTER)).
REQ-003 SHALL have parameter NUM_DEF_MASTER, default 0: master granted when no request is pending.
REQ-004 SHALL have port HCLK  input  1  bus clock; all state changes on its rising edge.
REQ-005 SHALL have port HRESETn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port HBUSREQ  input  N_MASTER  per-master bus request.
REQ-007 SHALL have port HLOCK  input  N_MASTER  per-master locked-transfer request.
REQ-008 SHALL have ports HTRANS  input  2,  HBURST  input  3, and HREADY  input  1, all taken from the shared bus.
REQ-009 SHALL have ports HRESP  input  2 and HSPLIT  input  N_MASTER, the muxed slave response and the OR of the slave split-release vectors.
REQ-010 SHALL have port HGRANT  output  N_MASTER  one-hot registered grant.
REQ-011 SHALL have port HMASTER  output  W_MASTER  address-phase owner.
REQ-012 SHALL have port HMASTER_del  output  W_MASTER  data-phase owner.
REQ-013 SHALL have port HMASTLOCK  output  1  current address phase is locked.

Function
REQ-014 SHALL use these encodings: HTRANS IDLE=0, BUSY=1, NONSEQ=2, SEQ=3; HBURST SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7; HRESP OKAY=0, ERROR=1, RETRY=2, SPLIT=3.
REQ-015 SHALL keep a beat counter rem (5 bits): load len-1 on an HREADY=1 edge with HTRANS=NONSEQ, where len is 1/4/8/16 for fixed bursts and 0 for INCR; decrement on an HREADY=1 edge with HTRANS=SEQ; saturate at 0.
REQ-016 SHALL treat an edge as an arbitration point when HREADY=1, the owner's HLOCK=0, and any of the following holds: HTRANS is IDLE or BUSY; the burst is SINGLE or INCR; or rem after that edge is <=1.
REQ-017 SHALL, at an arbitration point, grant the first requesting unmasked master in round-robin order, starting at HMASTER+1 and wrapping at N_MASTER-1 to 0.
REQ-018 SHALL grant NUM_DEF_MASTER when no unmasked master requests.
REQ-019 SHALL hold HGRANT unchanged at every edge that is not an arbitration point.
REQ-020 SHALL update HMASTER to the index of HGRANT, and HMASTER_del to the old HMASTER, on every edge with HREADY=1; both are held while HREADY=0.
REQ-021 SHALL update HMASTLOCK to HLOCK[granted master] on every edge with HREADY=1.
REQ-022 SHALL keep HGRANT with a locked owner (HLOCK high) until that owner deasserts HLOCK and an arbitration point occurs.
REQ-023 SHALL, on the first SPLIT cycle (HRESP=SPLIT, HREADY=0), set mask[HMASTER_del] and force the next HREADY=1 edge to be an arbitration point, including mid-burst.
REQ-024 SHALL clear mask[i] on an edge with HSPLIT[i]=1; when a set and a clear hit the same bit on the same edge, the set wins.
REQ-025 SHALL grant NUM_DEF_MASTER when every requester is masked; the default master's own request is then ignored.

Reset
REQ-026 SHALL, while HRESETn=0, drive HGRANT=one-hot(NUM_DEF_MASTER), HMASTER=HMASTER_del=NUM_DEF_MASTER, HMASTLOCK=0, mask=0, and rem=0.
REQ-027 SHALL, when reset asserts mid-burst, abandon the burst with no pending grant retained; the first edge after release is an arbitration point.

Configuration
REQ-028 SHALL compile the split mask logic of REQ-023..REQ-025 only when macro AHB_ARB_SPLIT_EN is defined.
REQ-029 SHALL, without AHB_ARB_SPLIT_EN, ignore HSPLIT, tie mask to 0, and treat HRESP=SPLIT like OKAY for arbitration purposes.

Structure
REQ-030 SHALL place the HTRANS/HBURST/HRESP encodings and a burst-length function (HBURST -> 0/1/4/8/16) in shared package ahb_arb_pkg.
REQ-031 SHALL implement the round-robin selection (request vector, pointer -> one-hot, valid) in combinational sub-module ahb_rr_pick.

Verification
REQ-032 SHALL check reset: with HRESETn=0, HGRANT=3'b001, HMASTER=0, HMASTLOCK=0; on release with HBUSREQ=3'b100, HGRANT=3'b100 after the first edge.
REQ-033 SHALL check round-robin: with HMASTER=1 and HBUSREQ=3'b111 on an IDLE transfer, the grant sequence over three arbitration points is m2, m0, m1.
REQ-034 SHALL check burst hold: m1 issues INCR4 with HREADY=1 while m2 requests; HGRANT moves to m2 at the edge accepting beat 3, HMASTER=2 after beat 4, and one wait state delays both changes by one cycle.
REQ-035 SHALL check lock: with m0 HLOCK=1 over two SINGLE transfers and m1 requesting, HGRANT stays on m0 and HMASTLOCK=1; m1 is granted at the first arbitration point after HLOCK falls.
REQ-036 SHALL check split (AHB_ARB_SPLIT_EN defined): a SPLIT response to m1 mid-INCR8 sets mask bit 1 and grants m2 at the next HREADY edge; m1 is not granted while requesting until HSPLIT=3'b010, then is granted at the next arbitration point.
REQ-037 SHALL check all masked: with mask=3'b110 and HBUSREQ=3'b110, HGRANT=3'b001.
